// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour type and test-bar palette
// for the Simon Says display controller.
package vga_pkg;

  localparam int RGB_W = 12;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HR = 96;
  localparam int HB = 48;
  localparam int HT = HD + HF + HR + HB;

  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VR = 2;
  localparam int VB = 33;
  localparam int VT = VD + VF + VR + VB;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t BAR_WHITE   = 12'hFFF;
  localparam rgb_t BAR_YELLOW  = 12'hFF0;
  localparam rgb_t BAR_CYAN    = 12'h0FF;
  localparam rgb_t BAR_GREEN   = 12'h0F0;
  localparam rgb_t BAR_MAGENTA = 12'hF0F;
  localparam rgb_t BAR_RED     = 12'hF00;
  localparam rgb_t BAR_BLUE    = 12'h00F;
  localparam rgb_t BAR_BLACK   = 12'h000;

  // Colour of the vertical test bar picked by h[9:7].
  function automatic rgb_t test_bar(input logic [2:0] idx);
    rgb_t c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// Pixel-tick divider plus horizontal/vertical raster counters
// and the line/frame start strobes.
module vga_raster_counter #(
  parameter int CLK_DIV = 4,
  parameter int HT      = 800,
  parameter int VT      = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       tick;

  assign tick        = enable && (div_q == 4'(CLK_DIV - 1));
  assign pixel_tick  = tick;
  assign line_start  = tick && (h_q == 10'd0);
  assign frame_start = line_start && (v_q == 10'd0);
  assign h           = h_q;
  assign v           = v_q;

  // Next divider/counter state; idle forces everything back to origin.
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (!enable) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = tick ? 4'd0 : div_q + 4'd1;
      if (tick) begin
        if (h_q == 10'(HT - 1)) begin
          h_d = '0;
          v_d = (v_q == 10'(VT - 1)) ? 10'd0 : v_q + 10'd1;
        end else begin
          h_d = h_q + 10'd1;
        end
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA raster sequencer with fixed-priority layer arbitration.
// Optional macro VGA_TEST_PATTERN_EN adds test_mode colour bars.
module vga_display_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int HD      = vga_pkg::HD,
  parameter int HF      = vga_pkg::HF,
  parameter int HR      = vga_pkg::HR,
  parameter int HB      = vga_pkg::HB,
  parameter int VD      = vga_pkg::VD,
  parameter int VF      = vga_pkg::VF,
  parameter int VR      = vga_pkg::VR,
  parameter int VB      = vga_pkg::VB
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                       test_mode,
`endif
  input  logic [2:0]                 layer_req,
  input  logic [3*vga_pkg::RGB_W-1:0] layer_rgb,
  input  logic [vga_pkg::RGB_W-1:0]  bg_rgb,
  output logic [9:0]                 x_pos,
  output logic [9:0]                 y_pos,
  output logic                       pixel_tick,
  output logic                       line_start,
  output logic                       frame_start,
  output logic                       h_sync,
  output logic                       v_sync,
  output logic                       video_on,
  output logic [vga_pkg::RGB_W-1:0]  rgb,
  output logic [2:0]                 layer_grant
);

  import vga_pkg::*;

  localparam int H_TOT = HD + HF + HR + HB;
  localparam int V_TOT = VD + VF + VR + VB;

  logic [9:0] h, v;
  logic       tick;
  logic       active;

  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  rgb_t       rgb_q, rgb_d;
  logic [2:0] gnt_q, gnt_d;

  vga_raster_counter #(
    .CLK_DIV (CLK_DIV),
    .HT      (H_TOT),
    .VT      (V_TOT)
  ) u_cnt (
    .clk         (clk),
    .rst         (reset),
    .enable      (enable),
    .h           (h),
    .v           (v),
    .pixel_tick  (tick),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  assign x_pos      = h;
  assign y_pos      = v;
  assign pixel_tick = tick;
  assign active     = (h < 10'(HD)) && (v < 10'(VD));

  // Decode of the current pixel, captured only on pixel_tick.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    von_d = von_q;
    rgb_d = rgb_q;
    gnt_d = gnt_q;
    if (!enable) begin
      hs_d  = 1'b1;
      vs_d  = 1'b1;
      von_d = 1'b0;
      rgb_d = '0;
      gnt_d = '0;
    end else if (tick) begin
      hs_d  = !((h >= 10'(HD + HF)) &&
                (h <  10'(HD + HF + HR)));
      vs_d  = !((v >= 10'(VD + VF)) &&
                (v <  10'(VD + VF + VR)));
      von_d = active;
      rgb_d = '0;
      gnt_d = '0;
      if (active) begin
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
          rgb_d = test_bar(h[9:7]);
        end else
`endif
        if (layer_req[0]) begin
          rgb_d = layer_rgb[0*RGB_W +: RGB_W];
          gnt_d = 3'b001;
        end else if (layer_req[1]) begin
          rgb_d = layer_rgb[1*RGB_W +: RGB_W];
          gnt_d = 3'b010;
        end else if (layer_req[2]) begin
          rgb_d = layer_rgb[2*RGB_W +: RGB_W];
          gnt_d = 3'b100;
        end else begin
          rgb_d = bg_rgb;
        end
      end
    end
  end

  // Output stage, one pixel behind the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b0;
      rgb_q <= '0;
      gnt_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      rgb_q <= rgb_d;
      gnt_q <= gnt_d;
    end
  end

  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign video_on    = von_q;
  assign rgb         = rgb_q;
  assign layer_grant = gnt_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl: elapsed-clock raster model plus
// directed literal checks. Vertical timing shrunk to keep runs short.
module tb_vga_display_ctrl;

  localparam int CD  = 4;
  localparam int HD  = 640;
  localparam int HF  = 16;
  localparam int HR  = 96;
  localparam int HB  = 48;
  localparam int VD  = 4;
  localparam int VF  = 1;
  localparam int VR  = 2;
  localparam int VB  = 1;
  localparam int HT  = HD + HF + HR + HB;
  localparam int VT  = VD + VF + VR + VB;
  localparam int LIM = 40000;

  logic        clk = 0;
  logic        reset = 1;
  logic        enable = 0;
  logic [2:0]  layer_req = 0;
  logic [11:0] c0 = 12'h111;
  logic [11:0] c1 = 12'h0F0;
  logic [11:0] c2 = 12'h00F;
  logic [11:0] bg_rgb = 12'h123;
  logic [9:0]  x_pos, y_pos;
  logic        pixel_tick, line_start, frame_start;
  logic        h_sync, v_sync, video_on;
  logic [11:0] rgb;
  logic [2:0]  layer_grant;
  logic        tm = 0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  vga_display_ctrl #(
    .CLK_DIV (CD),
    .HD (HD), .HF (HF), .HR (HR), .HB (HB),
    .VD (VD), .VF (VF), .VR (VR), .VB (VB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode   (tm),
`endif
    .layer_req   (layer_req),
    .layer_rgb   ({c2, c1, c0}),
    .bg_rgb      (bg_rgb),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .pixel_tick  (pixel_tick),
    .line_start  (line_start),
    .frame_start (frame_start),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .video_on    (video_on),
    .rgb         (rgb),
    .layer_grant (layer_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h exp=%0h t=%0t",
                 nm, got, exp, $time);
    end
  endtask

  // ---- model: n = clocks run since enable, outputs from pixel arithmetic
  int          n = 0;
  logic        ehs = 1, evs = 1, evon = 0;
  logic [11:0] ergb = 0;
  logic [2:0]  egnt = 0;

  function automatic logic [11:0] bar(input int hh);
    logic [11:0] t [8];
    t = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
          12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return t[(hh / 128) % 8];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      n = 0;
      ehs = 1; evs = 1; evon = 0; ergb = 0; egnt = 0;
    end else begin
      if (n % CD == CD - 1) begin
        int p, hh, vv;
        logic act;
        p  = n / CD;
        hh = p % HT;
        vv = (p / HT) % VT;
        act  = (hh < HD) && (vv < VD);
        ehs  = !(hh >= HD + HF && hh < HD + HF + HR);
        evs  = !(vv >= VD + VF && vv < VD + VF + VR);
        evon = act;
        ergb = 0;
        egnt = 0;
        if (act) begin
`ifdef VGA_TEST_PATTERN_EN
          if (tm) ergb = bar(hh);
          else
`endif
          if (layer_req[0]) begin ergb = c0; egnt = 3'b001; end
          else if (layer_req[1]) begin ergb = c1; egnt = 3'b010; end
          else if (layer_req[2]) begin ergb = c2; egnt = 3'b100; end
          else ergb = bg_rgb;
        end
      end
      n++;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    int p, ex, ey;
    logic et, el, ef;
    p  = n / CD;
    ex = p % HT;
    ey = (p / HT) % VT;
    et = enable && !reset && (n % CD == CD - 1);
    el = et && ex == 0;
    ef = el && ey == 0;
    chk("x_pos", 32'(x_pos), 32'(ex));
    chk("y_pos", 32'(y_pos), 32'(ey));
    chk("pixel_tick", 32'(pixel_tick), 32'(et));
    chk("line_start", 32'(line_start), 32'(el));
    chk("frame_start", 32'(frame_start), 32'(ef));
    chk("h_sync", 32'(h_sync), 32'(ehs));
    chk("v_sync", 32'(v_sync), 32'(evs));
    chk("video_on", 32'(video_on), 32'(evon));
    chk("rgb", 32'(rgb), 32'(ergb));
    chk("layer_grant", 32'(layer_grant), 32'(egnt));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---- directed sequence with hand-computed literals
  initial begin
    int k, t, c0s;
    repeat (3) step();
    chk("rst_x", 32'(x_pos), 0);
    chk("rst_hs", 32'(h_sync), 1);
    chk("rst_vs", 32'(v_sync), 1);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_gnt", 32'(layer_grant), 0);
    chk("rst_tick", 32'(pixel_tick), 0);

    reset = 0;
    enable = 1;
    layer_req = 3'b110;
    k = 1;
    for (int i = 0; i < 20 && !pixel_tick; i++) begin
      step();
      k++;
    end
    chk("first_tick_clk", 32'(k), 4);
    chk("first_frame_start", 32'(frame_start), 1);
    c0s = cyc;

    t = 1;
    for (int i = 0; i < LIM && h_sync; i++) begin
      step();
      if (h_sync && pixel_tick) t++;
    end
    chk("hsync_fall_ticks", 32'(t), 657);
    t = 0;
    for (int i = 0; i < LIM && !h_sync; i++) begin
      step();
      if (!h_sync && pixel_tick) t++;
    end
    chk("hsync_low_ticks", 32'(t), 96);

    for (int i = 0; i < LIM &&
         !(x_pos == 100 && y_pos == 2 && pixel_tick); i++)
      step();
    chk("reach_100_2", 32'(x_pos), 100);
    step();
    chk("prio_rgb", 32'(rgb), 32'h0F0);
    chk("prio_gnt", 32'(layer_grant), 32'b010);
    layer_req = 3'b000;
    for (int i = 0; i < 20 && !pixel_tick; i++) step();
    step();
    chk("bg_rgb", 32'(rgb), 32'h123);
    chk("bg_gnt", 32'(layer_grant), 0);

    layer_req = 3'b111;
    for (int i = 0; i < LIM && !(x_pos == 700 && pixel_tick); i++)
      step();
    step();
    chk("blank_rgb", 32'(rgb), 0);
    chk("blank_gnt", 32'(layer_grant), 0);
    chk("blank_von", 32'(video_on), 0);

    for (int i = 0; i < LIM && v_sync; i++) step();
    chk("vsync_line", 32'(y_pos), 5);
    chk("vsync_x", 32'(x_pos), 1);
    t = 0;
    for (int i = 0; i < LIM && !v_sync; i++) begin
      step();
      if (!v_sync && pixel_tick) t++;
    end
    chk("vsync_low_ticks", 32'(t), 1600);

    for (int i = 0; i < LIM && !frame_start; i++) step();
    chk("frame_period", 32'(cyc - c0s), 32'(HT * VT * CD));

    for (int i = 0; i < LIM &&
         !(x_pos == 300 && y_pos == 3); i++) begin
      step();
      layer_req = 3'($urandom_range(0, 7));
    end
    chk("reach_300_3", 32'(x_pos), 300);
    enable = 0;
    step();
    chk("dis_x", 32'(x_pos), 0);
    chk("dis_y", 32'(y_pos), 0);
    chk("dis_hs", 32'(h_sync), 1);
    chk("dis_vs", 32'(v_sync), 1);
    chk("dis_rgb", 32'(rgb), 0);
    enable = 1;
    k = 1;
    for (int i = 0; i < 20 && !pixel_tick; i++) begin
      step();
      k++;
    end
    chk("reen_tick_clk", 32'(k), 4);
    chk("reen_frame", 32'(frame_start), 1);

`ifdef VGA_TEST_PATTERN_EN
    tm = 1;
    for (int i = 0; i < LIM && !(x_pos == 0 && pixel_tick); i++)
      step();
    step();
    chk("bar_white", 32'(rgb), 32'hFFF);
    chk("bar_gnt", 32'(layer_grant), 0);
    for (int i = 0; i < LIM && !(x_pos == 128 && pixel_tick); i++)
      step();
    step();
    chk("bar_yellow", 32'(rgb), 32'hFF0);
    tm = 0;
`endif

    for (int i = 0; i < LIM && x_pos != 50; i++) step();
    layer_req = 3'b000;
    for (int i = 0; i < 20 && !pixel_tick; i++) step();
    step();
    reset = 1;
    #1;
    chk("arst_x", 32'(x_pos), 0);
    chk("arst_hs", 32'(h_sync), 1);
    chk("arst_rgb", 32'(rgb), 0);
    chk("arst_tick", 32'(pixel_tick), 0);
    step();
    reset = 0;
    repeat (400) begin
      step();
      layer_req = 3'($urandom_range(0, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
